echo_requester: RTL and testbench
=================================

Name: echo_requester

Overview:
Request-side counterpart of the echo block: generates a programmed sequence of say requests and consumes the returned heard indications. An internal scoreboard FIFO holds outstanding request values; each indication is checked against it for in-order equality. Used as a self-checking traffic source/sink in front of the echo block in simulation and on-chip loopback.

Parameters:
DEPTH, 4, scoreboard FIFO entries, i.e. the maximum number of outstanding requests (power of 2, at least 2).
WIDTH, 32, data width of say_v and heard_v.
CNTW, 16, width of the sequence-length and statistics counters.

Ports:
CLK  in  1  clock
nRST  in  1  synchronous active-low reset
start__ENA  in  1  start a run; honoured only when start__RDY=1
start_count  in  CNTW  number of requests N to issue
start_base  in  WIDTH  first request value
start__RDY  out  1  high in IDLE and DONE
say__ENA  out  1  request strobe toward the echo block
say_v  out  WIDTH  request value
say__RDY  in  1  echo block can accept a request
heard__ENA  in  1  indication strobe from the echo block
heard_v  in  WIDTH  indication value
heard__RDY  out  1  requester can accept an indication
busy  out  1  state is RUN
done  out  1  state is DONE
pass  out  1  done and mismatch_count==0 and unexpected_count==0
match_count  out  CNTW  indications equal to the expected value
mismatch_count  out  CNTW  indications not equal to the expected value
unexpected_count  out  CNTW  heard__ENA pulses while heard__RDY=0
first_bad_v  out  WIDTH  heard_v of the first mismatching indication

Behaviour:
- Reset (nRST=0 at posedge): state IDLE; FIFO empty; sent counter, all statistics counters and first_bad_v cleared to 0. Outputs: say__ENA=0, heard__RDY=0, busy=0, done=0, pass=0. Reset mid-run discards all outstanding entries.
- Handshake rule: a transfer occurs on a cycle where ENA and RDY are both high. say__ENA is never asserted unless say__RDY is high in the same cycle.
- State machine:
  - IDLE/DONE + start__ENA: latch N and base; clear sent, all statistics counters and first_bad_v. Go to RUN; if N==0, go directly to DONE instead.
  - RUN: say__ENA = (sent<N) && (occupancy<DEPTH) && say__RDY. say_v = base+sent, modulo 2^WIDTH, so values wrap. Combinationally valid in the same cycle as say__ENA.
  - On a say transfer: push say_v into the FIFO and increment sent. Maximum throughput is one request per cycle. The first say__ENA can occur in the cycle after start is accepted.
  - RUN transitions to DONE in the cycle after sent==N and occupancy==0 are both true.
  - DONE holds the statistics until the next start or reset.
- Indication side:
  - heard__RDY = (state==RUN) && (occupancy>0).
  - On a heard transfer: pop the FIFO head and compare it to heard_v.
    - Equal: increment match_count.
    - Not equal: increment mismatch_count. If mismatch_count was 0, capture first_bad_v = heard_v.
  - heard__ENA with heard__RDY=0 (in any state, including IDLE and DONE): increment unexpected_count, no FIFO change.
  - The echo block latency is therefore irrelevant to the requester.
- Simultaneous push and pop in one cycle: both take effect and occupancy is unchanged. A pop from an empty FIFO or a push to a full FIFO is impossible by construction.
- Counters saturate at 2^CNTW-1.
- start__ENA while RUN is ignored (start__RDY=0).

Test Plan:
- Start N=4, base 0x10; echo responds in order with 2-cycle latency -> say_v 0x10..0x13, match_count=4, mismatch_count=0, done=1, pass=1.
- Hold heard__ENA low with N=8, DEPTH=4 -> exactly 4 say transfers, then say__ENA=0. Release heard -> remaining 4 are issued, match_count=8, pass=1.
- Toggle say__RDY low for 3 cycles mid-run -> say__ENA is never high while say__RDY=0, no value is skipped or duplicated, final match_count=N.
- Return 0x99 in place of 0x12 (N=4, base 0x10) -> mismatch_count=1, first_bad_v=0x99, match_count=3, pass=0.
- Pulse heard__ENA in IDLE -> unexpected_count=1. Start N=0 -> done=1 next cycle, pass=1, no say__ENA.
- Base 0xFFFFFFFE, N=3 -> say_v 0xFFFFFFFE, 0xFFFFFFFF, 0x0, pass=1. Assert nRST=0 mid-run with 2 outstanding -> IDLE, all outputs zero, heard__RDY=0.

Source files
------------

// File: rtl/echo_requester.sv
// Self-checking request source / indication sink for the echo block.
// Issues base, base+1, ... and checks the echoed values in order against a small scoreboard FIFO.
module echo_requester #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start__ENA,
    input  logic [CNTW-1:0]  start_count,
    input  logic [WIDTH-1:0] start_base,
    output logic             start__RDY,
    output logic             say__ENA,
    output logic [WIDTH-1:0] say_v,
    input  logic             say__RDY,
    input  logic             heard__ENA,
    input  logic [WIDTH-1:0] heard_v,
    output logic             heard__RDY,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNTW-1:0]  match_count,
    output logic [CNTW-1:0]  mismatch_count,
    output logic [CNTW-1:0]  unexpected_count,
    output logic [WIDTH-1:0] first_bad_v,
    output logic [1:0]       state_dbg
);
    // Handshake: a transfer happens on any cycle where ENA and RDY are both high;
    // say__ENA already includes say__RDY, so it is only high on real transfers.

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNTW-1:0]  count_q;
    logic [CNTW-1:0]  sent_q;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] fifo_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;

    logic heard_xfer;
    logic heard_stray;
    logic head_match;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    always_comb begin
        say__ENA    = (state == S_RUN) && (sent_q < count_q) && (occ != FULL_OCC) && say__RDY;
        say_v       = base_q + WIDTH'(sent_q);
        heard__RDY  = (state == S_RUN) && (occ != '0);
        heard_xfer  = heard__ENA && heard__RDY;
        heard_stray = heard__ENA && !heard__RDY;
        head_match  = (fifo_mem[rd_ptr] == heard_v);
        start__RDY  = (state != S_RUN);
        busy        = (state == S_RUN);
        done        = (state == S_DONE);
        pass        = (state == S_DONE) && (mismatch_count == '0) && (unexpected_count == '0);
        state_dbg   = state;
    end

    // Scoreboard storage needs no reset: occupancy gates every read.
    always_ff @(posedge CLK) begin
        if (say__ENA) begin
            fifo_mem[wr_ptr] <= say_v;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state            <= S_IDLE;
            count_q          <= '0;
            sent_q           <= '0;
            base_q           <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            occ              <= '0;
            match_count      <= '0;
            mismatch_count   <= '0;
            unexpected_count <= '0;
            first_bad_v      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start__ENA) begin
                        count_q          <= start_count;
                        base_q           <= start_base;
                        sent_q           <= '0;
                        match_count      <= '0;
                        mismatch_count   <= '0;
                        unexpected_count <= '0;
                        first_bad_v      <= '0;
                        state            <= (start_count == '0) ? S_DONE : S_RUN;
                    end else if (heard_stray) begin
                        unexpected_count <= sat_inc(unexpected_count);
                    end
                end
                S_RUN: begin
                    if (heard_stray) begin
                        unexpected_count <= sat_inc(unexpected_count);
                    end
                    if (say__ENA) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        sent_q <= sent_q + CNTW'(1);
                    end
                    if (heard_xfer) begin
                        rd_ptr <= rd_ptr + AW'(1);
                        if (head_match) begin
                            match_count <= sat_inc(match_count);
                        end else begin
                            mismatch_count <= sat_inc(mismatch_count);
                            if (mismatch_count == '0) begin
                                first_bad_v <= heard_v;
                            end
                        end
                    end
                    case ({say__ENA, heard_xfer})
                        2'b10:   occ <= occ + (AW+1)'(1);
                        2'b01:   occ <= occ - (AW+1)'(1);
                        default: occ <= occ;
                    endcase
                    // Finish only once everything issued has also been answered.
                    if ((sent_q == count_q) && (occ == '0)) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_echo_requester.sv
// Directed bench for echo_requester: a 2-cycle echo responder plus a queue-based
// reference model checked every cycle, and literal end-of-test expectations.
module tb_echo_requester;
    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int CNTW  = 16;

    logic             CLK;
    logic             nRST;
    logic             start__ENA;
    logic [CNTW-1:0]  start_count;
    logic [WIDTH-1:0] start_base;
    logic             start__RDY;
    logic             say__ENA;
    logic [WIDTH-1:0] say_v;
    logic             say__RDY;
    logic             heard__ENA;
    logic [WIDTH-1:0] heard_v;
    logic             heard__RDY;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNTW-1:0]  match_count;
    logic [CNTW-1:0]  mismatch_count;
    logic [CNTW-1:0]  unexpected_count;
    logic [WIDTH-1:0] first_bad_v;
    logic [1:0]       state_dbg;

    echo_requester #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .CLK(CLK), .nRST(nRST),
        .start__ENA(start__ENA), .start_count(start_count), .start_base(start_base),
        .start__RDY(start__RDY),
        .say__ENA(say__ENA), .say_v(say_v), .say__RDY(say__RDY),
        .heard__ENA(heard__ENA), .heard_v(heard_v), .heard__RDY(heard__RDY),
        .busy(busy), .done(done), .pass(pass),
        .match_count(match_count), .mismatch_count(mismatch_count),
        .unexpected_count(unexpected_count), .first_bad_v(first_bad_v),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Responder controls (written only by the main process)
    logic        hold_heard = 1'b0;
    logic        bad_en     = 1'b0;
    logic [31:0] bad_from   = '0;
    logic [31:0] bad_to     = '0;
    int          stray_req  = 0;

    // Echo responder state and observed say values (written only by the cycle process)
    logic [31:0] echo_v_q[$];
    int          echo_t_q[$];
    logic [31:0] said_q[$];
    int          stray_done = 0;
    int          cyc = 0;

    // Reference model
    logic        m_valid = 1'b0;
    logic        m_running, m_done;
    logic [15:0] m_n, m_sent, m_match, m_mism, m_unexp;
    logic [31:0] m_base, m_first_bad;
    logic [31:0] m_exp_q[$];
    logic        p_say, p_hrdy, p_pass;
    logic [31:0] p_sayv, e;

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---------------- per-cycle responder, compare and model ----------------
    initial begin
        heard__ENA = 1'b0;
        heard_v    = '0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (echo_v_q.size() > 0 && !hold_heard && echo_t_q[0] <= cyc) begin
                heard__ENA = 1'b1;
                heard_v    = (bad_en && echo_v_q[0] == bad_from) ? bad_to : echo_v_q[0];
                void'(echo_v_q.pop_front());
                void'(echo_t_q.pop_front());
            end else if (stray_req != stray_done) begin
                heard__ENA = 1'b1;
                heard_v    = 32'h5A5A_0000;
                stray_done = stray_req;
            end else begin
                heard__ENA = 1'b0;
                heard_v    = '0;
            end
            #1;
            p_hrdy = m_running && (m_exp_q.size() > 0);
            p_say  = m_running && (m_sent < m_n) && (m_exp_q.size() < DEPTH) && say__RDY;
            p_sayv = m_base + 32'(m_sent);
            p_pass = m_done && (m_mism == 0) && (m_unexp == 0);
            if (m_valid) begin
                chk("say__ENA", say__ENA, p_say);
                if (p_say) chk("say_v", say_v, p_sayv);
                chk("heard__RDY", heard__RDY, p_hrdy);
                chk("start__RDY", start__RDY, !m_running);
                chk("busy", busy, m_running);
                chk("done", done, m_done);
                chk("pass", pass, p_pass);
                chk("match_count", match_count, m_match);
                chk("mismatch_count", mismatch_count, m_mism);
                chk("unexpected_count", unexpected_count, m_unexp);
                chk("first_bad_v", first_bad_v, m_first_bad);
            end
            if (say__ENA && say__RDY) begin
                echo_v_q.push_back(say_v);
                echo_t_q.push_back(cyc + 2);
                said_q.push_back(say_v);
            end
            // Advance the model to what the coming clock edge must produce.
            if (!nRST) begin
                m_valid = 1'b1; m_running = 1'b0; m_done = 1'b0;
                m_n = '0; m_sent = '0; m_base = '0;
                m_match = '0; m_mism = '0; m_unexp = '0; m_first_bad = '0;
                m_exp_q.delete(); echo_v_q.delete(); echo_t_q.delete();
            end else if (m_valid) begin
                if (!m_running && start__ENA) begin
                    m_n = start_count; m_base = start_base; m_sent = '0;
                    m_match = '0; m_mism = '0; m_unexp = '0; m_first_bad = '0;
                    m_exp_q.delete();
                    m_running = (start_count != 0);
                    m_done    = (start_count == 0);
                end else begin
                    if (heard__ENA && !p_hrdy) m_unexp = sat16(m_unexp);
                    if (m_running) begin
                        if (m_sent == m_n && m_exp_q.size() == 0) begin
                            m_running = 1'b0;
                            m_done    = 1'b1;
                        end else begin
                            if (p_say) begin
                                m_exp_q.push_back(p_sayv);
                                m_sent = m_sent + 16'd1;
                            end
                            if (heard__ENA && p_hrdy) begin
                                e = m_exp_q.pop_front();
                                if (e == heard_v) m_match = sat16(m_match);
                                else begin
                                    if (m_mism == 0) m_first_bad = heard_v;
                                    m_mism = sat16(m_mism);
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic start_run(input logic [15:0] n, input logic [31:0] base);
        start_count = n;
        start_base  = base;
        start__ENA  = 1'b1;
        wait_cycles(1);
        start__ENA  = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (done !== 1'b1 && k < limit) begin
            wait_cycles(1);
            k++;
        end
        chk("done_within_budget", done, 1'b1);
    endtask

    task automatic apply_reset();
        nRST = 1'b0;
        wait_cycles(2);
        nRST = 1'b1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        nRST        = 1'b0;
        start__ENA  = 1'b0;
        start_count = '0;
        start_base  = '0;
        say__RDY    = 1'b1;
        wait_cycles(2);
        chk("rst_say_ena", say__ENA, 1'b0);
        chk("rst_heard_rdy", heard__RDY, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        nRST = 1'b1;
        wait_cycles(1);

        // In-order echo, N=4 from 0x10
        said_q.delete();
        start_run(16'd4, 32'h10);
        wait_done(50);
        chk("t1_count", said_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("t1_say_v", said_q[i], 32'h10 + i);
        chk("t1_match", match_count, 16'd4);
        chk("t1_mismatch", mismatch_count, 16'd0);
        chk("t1_pass", pass, 1'b1);

        // Back-pressure from withheld indications: only DEPTH requests outstanding
        said_q.delete();
        hold_heard = 1'b1;
        start_run(16'd8, 32'h100);
        wait_cycles(10);
        chk("t2_held_count", said_q.size(), 4);
        chk("t2_held_say_ena", say__ENA, 1'b0);
        hold_heard = 1'b0;
        wait_done(60);
        chk("t2_count", said_q.size(), 8);
        for (int i = 0; i < 8; i++) chk("t2_say_v", said_q[i], 32'h100 + i);
        chk("t2_match", match_count, 16'd8);
        chk("t2_pass", pass, 1'b1);

        // say__RDY low for 3 cycles mid-run
        said_q.delete();
        start_run(16'd6, 32'h200);
        wait_cycles(2);
        say__RDY = 1'b0;
        wait_cycles(3);
        say__RDY = 1'b1;
        wait_done(60);
        chk("t3_count", said_q.size(), 6);
        for (int i = 0; i < 6; i++) chk("t3_say_v", said_q[i], 32'h200 + i);
        chk("t3_match", match_count, 16'd6);

        // Corrupted indication: 0x99 returned instead of 0x12
        bad_en = 1'b1; bad_from = 32'h12; bad_to = 32'h99;
        start_run(16'd4, 32'h10);
        wait_done(50);
        bad_en = 1'b0;
        chk("t4_mismatch", mismatch_count, 16'd1);
        chk("t4_first_bad", first_bad_v, 32'h99);
        chk("t4_match", match_count, 16'd3);
        chk("t4_pass", pass, 1'b0);

        // Stray indication in IDLE, then an empty run
        apply_reset();
        stray_req++;
        wait_cycles(3);
        chk("t5_unexpected", unexpected_count, 16'd1);
        said_q.delete();
        start_run(16'd0, 32'h0);
        chk("t5_done", done, 1'b1);
        chk("t5_pass", pass, 1'b1);
        wait_cycles(3);
        chk("t5_no_say", said_q.size(), 0);

        // Value wrap at the top of the range
        said_q.delete();
        start_run(16'd3, 32'hFFFF_FFFE);
        wait_done(50);
        chk("t6_say_v0", said_q[0], 32'hFFFF_FFFE);
        chk("t6_say_v1", said_q[1], 32'hFFFF_FFFF);
        chk("t6_say_v2", said_q[2], 32'h0000_0000);
        chk("t6_pass", pass, 1'b1);

        // Reset with two requests outstanding
        said_q.delete();
        hold_heard = 1'b1;
        start_run(16'd8, 32'h300);
        for (int k = 0; k < 20 && said_q.size() < 2; k++) wait_cycles(1);
        say__RDY = 1'b0;
        nRST     = 1'b0;
        wait_cycles(1);
        chk("t7_outstanding", said_q.size(), 2);
        chk("t7_busy", busy, 1'b0);
        chk("t7_done", done, 1'b0);
        chk("t7_pass", pass, 1'b0);
        chk("t7_heard_rdy", heard__RDY, 1'b0);
        chk("t7_say_ena", say__ENA, 1'b0);
        chk("t7_start_rdy", start__RDY, 1'b1);
        chk("t7_match", match_count, 16'd0);
        nRST       = 1'b1;
        hold_heard = 1'b0;
        say__RDY   = 1'b1;
        wait_cycles(1);

        // Stale scoreboard entries must be gone after reset
        start_run(16'd2, 32'h40);
        wait_done(40);
        chk("t8_match", match_count, 16'd2);
        chk("t8_pass", pass, 1'b1);

        wait_cycles(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
